// File: rtl/iqft3_engine_seq.sv
// 3-qubit inverse QFT engine: captures one 8-amplitude vector, applies one gate per clock, holds the result until taken.
// Optional macro IQFT_SAT_EN clamps every gate result to the W-bit signed range instead of wrapping.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 8
`endif
module iqft3_engine_seq #(
    parameter int W         = `TOTAL_WIDTH,
    parameter int FRAC      = 4,
    parameter int INV_SQRT2 = 11,
    parameter int COS_PI_4  = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [16*W-1:0] in_state,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [16*W-1:0] out_state,
    output logic            busy
);
    localparam int PW = 2*W + 2;
    localparam logic signed [PW-1:0] K_H = PW'(INV_SQRT2);
    localparam logic signed [PW-1:0] K_C = PW'(COS_PI_4);

    typedef enum logic [3:0] {
        S_IDLE, S_SWP, S_H0, S_C10, S_H1, S_C20, S_C21, S_H2, S_OUT
    } state_t;

    state_t            state_q;
    logic              out_valid_q, in_ready_q, busy_q;
    logic [16*W-1:0]   st_q, st_d;
    logic signed [W-1:0] re [8];
    logic signed [W-1:0] im [8];
    logic signed [W-1:0] nre [8];
    logic signed [W-1:0] nim [8];
    int                hq;
    logic              h_en;

    function automatic logic signed [W-1:0] fit(input logic signed [PW-1:0] v);
`ifdef IQFT_SAT_EN
        logic signed [PW-1:0] hi, lo;
        hi = PW'((1 << (W-1)) - 1);
        lo = ~hi;
        if (v > hi)      return hi[W-1:0];
        else if (v < lo) return lo[W-1:0];
        else             return v[W-1:0];
`else
        return v[W-1:0];
`endif
    endfunction

    // ((a +/- b) * k) >>> FRAC with a wide intermediate so only the final write-back wraps or clamps
    function automatic logic signed [W-1:0] mulk(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b,
                                                 input logic sub,
                                                 input logic signed [PW-1:0] k);
        logic signed [PW-1:0] s, p;
        s = sub ? (PW'(a) - PW'(b)) : (PW'(a) + PW'(b));
        p = (s * k) >>> FRAC;
        return fit(p);
    endfunction

    function automatic logic signed [W-1:0] negf(input logic signed [W-1:0] a);
        return fit(-PW'(a));
    endfunction

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            re[k] = st_q[2*k*W +: W];
            im[k] = st_q[(2*k+1)*W +: W];
        end
        nre  = re;
        nim  = im;
        hq   = 0;
        h_en = 1'b0;
        case (state_q)
            S_SWP: begin
                nre[1] = re[4]; nim[1] = im[4]; nre[4] = re[1]; nim[4] = im[1];
                nre[3] = re[6]; nim[3] = im[6]; nre[6] = re[3]; nim[6] = im[3];
            end
            S_H0: begin h_en = 1'b1; hq = 0; end
            S_H1: begin h_en = 1'b1; hq = 1; end
            S_H2: begin h_en = 1'b1; hq = 2; end
            S_C10: begin
                nre[3] = im[3]; nim[3] = negf(re[3]);
                nre[7] = im[7]; nim[7] = negf(re[7]);
            end
            S_C20: begin
                nre[5] = mulk(re[5], im[5], 1'b0, K_C); nim[5] = mulk(im[5], re[5], 1'b1, K_C);
                nre[7] = mulk(re[7], im[7], 1'b0, K_C); nim[7] = mulk(im[7], re[7], 1'b1, K_C);
            end
            S_C21: begin
                nre[6] = im[6]; nim[6] = negf(re[6]);
                nre[7] = im[7]; nim[7] = negf(re[7]);
            end
            default: ;
        endcase
        if (h_en) begin
            for (int k = 0; k < 8; k++) begin
                if (((k >> hq) & 1) == 0) begin
                    nre[k]            = mulk(re[k], re[k | (1 << hq)], 1'b0, K_H);
                    nim[k]            = mulk(im[k], im[k | (1 << hq)], 1'b0, K_H);
                    nre[k | (1 << hq)] = mulk(re[k], re[k | (1 << hq)], 1'b1, K_H);
                    nim[k | (1 << hq)] = mulk(im[k], im[k | (1 << hq)], 1'b1, K_H);
                end
            end
        end
        st_d = st_q;
        for (int k = 0; k < 8; k++) begin
            st_d[2*k*W +: W]     = nre[k];
            st_d[(2*k+1)*W +: W] = nim[k];
        end
        if (state_q == S_IDLE && in_valid && in_ready_q) st_d = in_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            st_q        <= '0;
        end else begin
            st_q <= st_d;
            case (state_q)
                S_IDLE: if (in_valid && in_ready_q) begin
                    state_q    <= S_SWP;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                end
                S_SWP: state_q <= S_H0;
                S_H0:  state_q <= S_C10;
                S_C10: state_q <= S_H1;
                S_H1:  state_q <= S_C20;
                S_C20: state_q <= S_C21;
                S_C21: state_q <= S_H2;
                S_H2: begin
                    state_q     <= S_OUT;
                    out_valid_q <= 1'b1;
                end
                S_OUT: if (out_ready) begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_state = st_q;
endmodule

// File: tb/tb_iqft3_engine_seq.sv
// Bench for iqft3_engine_seq (W=8, FRAC=4): expected vectors are queued at accept time and compared on output.
`timescale 1ns/1ps
module tb_iqft3_engine_seq;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_state;
    logic         busy;

    iqft3_engine_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .busy(busy)
    );

    always #5 clk = ~clk;

    logic [127:0] exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;
    logic [127:0] V_IMP, E_IMP, V_A1, E_A1, V_OVF, E_OVF;

    function automatic logic [127:0] put(input logic [127:0] v, input int k, input int r, input int i);
        logic [127:0] t;
        t = v;
        t[2*k*8 +: 8]     = 8'(r);
        t[(2*k+1)*8 +: 8] = 8'(i);
        return t;
    endfunction

    task automatic build_vectors();
        int er[8] = '{4, 2, 0, -4, -5, -3, 0, 3};
        int ei[8] = '{0, -4, -5, -3, 0, 3, 4, 2};
        int ovf;
`ifdef IQFT_SAT_EN
        ovf = 59;
`else
        ovf = -40;
`endif
        V_IMP = put('0, 0, 16, 0);
        V_A1  = put('0, 1, 16, 0);
        V_OVF = put(put('0, 0, 127, 0), 4, 127, 0);
        E_IMP = '0; E_A1 = '0; E_OVF = '0;
        for (int k = 0; k < 8; k++) begin
            E_IMP = put(E_IMP, k, 4, 0);
            E_A1  = put(E_A1, k, er[k], ei[k]);
        end
        for (int k = 0; k < 8; k += 2) E_OVF = put(E_OVF, k, ovf, 0);
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic send(input logic [127:0] v, input logic [127:0] e, input bit push, output bit ok);
        int t;
        t = 0;
        in_state = v;
        in_valid = 1'b1;
        while (!in_ready && t < 40) begin @(negedge clk); t++; end
        ok = in_ready;
        if (ok && push) exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin @(negedge clk); cyc++; end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({out_valid, in_ready, busy} !== 3'b010 || out_state !== '0) begin
            n_miss++;
            $display("FAIL reset_values: v/r/b=%b state=%h, want 010 state=0", {out_valid, in_ready, busy}, out_state);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            n_miss++;
            $display("FAIL idle_after_reset: v/r/b=%b, want 010", {out_valid, in_ready, busy});
        end
    endtask

    task automatic test_impulse();
        bit ok; int cyc; logic [127:0] e;
        out_ready = 1'b1;
        send(V_IMP, E_IMP, 1'b1, ok);
        n_vec++;
        if (!ok || busy !== 1'b1) begin
            n_miss++; $display("FAIL impulse_accept: accepted=%0d busy=%b, want 1 1", ok, busy);
        end
        wait_out(cyc);
        n_vec++;
        if (cyc + 1 != 8) begin
            n_miss++; $display("FAIL impulse_latency: out_valid on edge %0d, want edge 8", cyc + 1);
        end
        n_vec++;
        if (!out_valid || exp_q.size() == 0) begin
            n_miss++; $display("FAIL impulse_result: no output (valid=%b)", out_valid); exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            if (out_state !== e) begin
                n_miss++; $display("FAIL impulse_result: got %h want %h", out_state, e);
            end
        end
        @(negedge clk);
        n_vec++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            n_miss++; $display("FAIL impulse_return_idle: v/r/b=%b, want 010", {out_valid, in_ready, busy});
        end
    endtask

    task automatic test_amp1();
        bit ok; int cyc; logic [127:0] e;
        out_ready = 1'b1;
        send(V_A1, E_A1, 1'b1, ok);
        wait_out(cyc);
        n_vec++;
        if (!ok || !out_valid || exp_q.size() == 0) begin
            n_miss++; $display("FAIL amp1_result: no output (accepted=%0d valid=%b)", ok, out_valid); exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            if (out_state !== e) begin
                n_miss++; $display("FAIL amp1_result: got %h want %h", out_state, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit ok; int cyc; logic [127:0] e;
        out_ready = 1'b0;
        send(V_IMP, E_IMP, 1'b1, ok);
        wait_out(cyc);
        in_state = V_A1;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (!out_valid || exp_q.size() == 0 || out_state !== exp_q[0] || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_miss++;
                $display("FAIL bp_hold[%0d]: valid=%b rdy=%b busy=%b state=%h, want 1 0 1 %h",
                         c, out_valid, in_ready, busy, out_state, E_IMP);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        n_vec++;
        if (!out_valid || exp_q.size() == 0) begin
            n_miss++; $display("FAIL bp_result: no output (valid=%b)", out_valid); exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            if (out_state !== e) begin
                n_miss++; $display("FAIL bp_result: got %h want %h", out_state, e);
            end
        end
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_miss++; $display("FAIL bp_release: valid=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
        if (in_ready) exp_q.push_back(E_A1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(cyc);
        n_vec++;
        if (!out_valid || exp_q.size() == 0) begin
            n_miss++; $display("FAIL bp_second: no output (valid=%b)", out_valid); exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            if (out_state !== e) begin
                n_miss++; $display("FAIL bp_second: got %h want %h", out_state, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        bit ok; int cyc; int bad; logic [127:0] e;
        out_ready = 1'b1;
        send(V_A1, '0, 1'b0, ok);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({out_valid, in_ready, busy} !== 3'b010 || out_state !== '0) begin
            n_miss++;
            $display("FAIL midrun_reset: v/r/b=%b state=%h, want 010 state=0", {out_valid, in_ready, busy}, out_state);
        end
        rst = 1'b0;
        bad = 0;
        repeat (12) begin @(negedge clk); if (out_valid !== 1'b0 || busy !== 1'b0) bad++; end
        n_vec++;
        if (bad != 0) begin
            n_miss++; $display("FAIL midrun_discard: %0d cycles with valid/busy, want 0", bad);
        end
        send(V_IMP, E_IMP, 1'b1, ok);
        wait_out(cyc);
        n_vec++;
        if (!out_valid || exp_q.size() == 0) begin
            n_miss++; $display("FAIL midrun_rerun: no output (valid=%b)", out_valid); exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            if (out_state !== e) begin
                n_miss++; $display("FAIL midrun_rerun: got %h want %h", out_state, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        bit ok; int cyc; logic [127:0] e;
        out_ready = 1'b1;
        send(V_OVF, E_OVF, 1'b1, ok);
        wait_out(cyc);
        n_vec++;
        if (!out_valid || exp_q.size() == 0) begin
            n_miss++; $display("FAIL overflow_result: no output (valid=%b)", out_valid); exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            if (out_state !== e) begin
                n_miss++; $display("FAIL overflow_result: got %h want %h", out_state, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [127:0] vv[2];
        logic [127:0] ee[2];
        logic [127:0] e;
        int acc[2];
        int nacc, nout, cyc;
        bit pend;
        vv[0] = V_IMP; ee[0] = E_IMP; vv[1] = V_A1; ee[1] = E_A1;
        acc[0] = 0; acc[1] = 0; nacc = 0; nout = 0; cyc = 0; pend = 1'b0;
        out_ready = 1'b1;
        in_state = vv[0];
        in_valid = 1'b1;
        while (nout < 2 && cyc < 100) begin
            if (pend) begin
                pend = 1'b0; nacc++;
                if (nacc < 2) in_state = vv[nacc]; else in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                acc[nacc] = cyc; exp_q.push_back(ee[nacc]); pend = 1'b1;
            end
            if (out_valid) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++; $display("FAIL b2b_result[%0d]: output with nothing expected", nout);
                end else begin
                    e = exp_q.pop_front();
                    if (out_state !== e) begin
                        n_miss++; $display("FAIL b2b_result[%0d]: got %h want %h", nout, out_state, e);
                    end
                end
                nout++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        n_vec++;
        if (nout != 2 || acc[1] - acc[0] != 9) begin
            n_miss++; $display("FAIL b2b_spacing: outputs=%0d spacing=%0d, want 2 and 9", nout, acc[1] - acc[0]);
        end
        exp_q.delete();
    endtask

    initial begin
        build_vectors();
        @(negedge clk);
        test_reset();
        test_impulse();
        test_amp1();
        test_backpressure();
        test_reset_midrun();
        test_overflow();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
